// File: rtl/uart_pixel_streamer_pkg.sv
// Shared types and defaults for the UART pixel streamer.
//   state_e : streamer FSM states
//   bsel_e  : which byte of the current entry goes out next
//   SYNC0_DEFAULT / SYNC1_DEFAULT : frame-header bytes
//   next_bsel() : byte-sequence successor (HDR0 -> HDR1 -> PIX_HI -> PIX_LO)
package uart_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GUARD
  } state_e;

  typedef enum logic [1:0] {
    HDR0,
    HDR1,
    PIX_HI,
    PIX_LO
  } bsel_e;

  localparam logic [7:0] SYNC0_DEFAULT = 8'hAA;
  localparam logic [7:0] SYNC1_DEFAULT = 8'h55;

  // FIFO entry layout: {sof, pixel}
  localparam int unsigned ENTRY_W = 17;

  function automatic bsel_e next_bsel(input bsel_e b);
    unique case (b)
      HDR0:    next_bsel = HDR1;
      HDR1:    next_bsel = PIX_HI;
      PIX_HI:  next_bsel = PIX_LO;
      default: next_bsel = PIX_LO;
    endcase
  endfunction

endpackage

// File: rtl/uart_pixel_streamer_if.sv
// Pixel stream bus from the capture logic into the streamer.
//   pix_data  : RGB565 pixel {hi_byte, lo_byte}
//   pix_valid : pixel present this cycle (source cannot stall)
//   pix_sof   : qualifies pix_valid, first pixel of a frame
//   pix_ready : sink FIFO not full
// master = pixel source, slave = streamer.
interface uart_pixel_streamer_if;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_sof;
  logic        pix_ready;

  modport master (
    output pix_data,
    output pix_valid,
    output pix_sof,
    input  pix_ready
  );

  modport slave (
    input  pix_data,
    input  pix_valid,
    input  pix_sof,
    output pix_ready
  );
endinterface

// File: rtl/uart_pixel_streamer_fifo.sv
// stream_fifo: synchronous FIFO with registered read data.
//   clk, reset     : clock, synchronous active-high reset
//   wr_en, din     : write request and data (ignored when full)
//   full           : no free entries
//   rd_en          : pop request (ignored when empty)
//   dout           : popped entry, valid the cycle after rd_en, held until the next pop
//   empty          : no stored entries
module stream_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Extra MSB separates full from empty when the index bits match.
  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] dout_q;
  logic             do_wr, do_rd;

  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_wr = wr_en && !full;
    do_rd = rd_en && !empty;
    dout  = dout_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      dout_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) begin
        rptr_q <= rptr_q + 1'b1;
        dout_q <= mem_q[rptr_q[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_pixel_streamer.sv
// uart_pixel_streamer: buffers RGB565 pixels and feeds them to a byte-wide UART
// transmitter, prefixing each frame with a 2-byte sync header.
//   clk, reset    : clock, synchronous active-high reset (shared with the transmitter)
//   pix           : pixel stream bus (slave side), pix_ready = FIFO not full
//   overflow      : sticky, a valid pixel was dropped because the FIFO was full
//   tx_data       : byte to transmitter, stable from tx_start until tx_byte_sent
//   tx_start      : one-cycle start pulse to transmitter
//   tx_byte_sent  : one-cycle pulse from transmitter at end of data bits
//   busy          : FSM active or FIFO holding pixels
module uart_pixel_streamer
  import uart_stream_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned GUARD_CYCLES = 436,
  parameter logic [7:0]  SYNC0        = SYNC0_DEFAULT,
  parameter logic [7:0]  SYNC1        = SYNC1_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_pixel_streamer_if.slave  pix,
  output logic                  overflow,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_byte_sent,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(GUARD_CYCLES + 1);

  state_e               state_q, state_d;
  bsel_e                bsel_q, eff_bsel;
  logic                 first_q;
  logic [CW-1:0]        guard_q;
  logic [7:0]           tx_data_q;
  logic [7:0]           byte_mux;
  logic                 overflow_q;
  logic                 guard_done;

  logic                 fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]   fifo_dout;

  stream_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (fifo_wr),
    .din   ({pix.pix_sof, pix.pix_data}),
    .full  (fifo_full),
    .rd_en (fifo_rd),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  assign fifo_wr       = pix.pix_valid && !fifo_full;
  assign pix.pix_ready = !fifo_full;
  assign overflow      = overflow_q;
  assign guard_done    = (guard_q == '0);

  // The popped entry only becomes readable in S_ISSUE, so the first byte of a pixel
  // resolves its header/pixel choice from the entry's sof bit there.
  always_comb begin
    if (first_q) eff_bsel = fifo_dout[16] ? HDR0 : PIX_HI;
    else         eff_bsel = bsel_q;
  end

  always_comb begin
    byte_mux = 8'h00;
    unique case (eff_bsel)
      HDR0:   byte_mux = SYNC0;
      HDR1:   byte_mux = SYNC1;
      PIX_HI: byte_mux = fifo_dout[15:8];
      PIX_LO: byte_mux = fifo_dout[7:0];
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (tx_byte_sent) state_d = S_GUARD;
      S_GUARD: begin
        if (guard_done) state_d = (bsel_q == PIX_LO) ? S_IDLE : S_ISSUE;
      end
    endcase
  end

  // FSM outputs; tx_data bypasses its register in S_ISSUE so data and start coincide.
  always_comb begin
    fifo_rd  = (state_q == S_IDLE) && !fifo_empty;
    tx_start = (state_q == S_ISSUE);
    tx_data  = (state_q == S_ISSUE) ? byte_mux : tx_data_q;
    busy     = (state_q != S_IDLE) || !fifo_empty;
  end

  // Datapath: byte select, guard counter, held tx byte, sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      bsel_q     <= HDR0;
      first_q    <= 1'b0;
      guard_q    <= '0;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      if (pix.pix_valid && fifo_full) overflow_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (!fifo_empty) first_q <= 1'b1;
        end
        S_ISSUE: begin
          first_q   <= 1'b0;
          bsel_q    <= eff_bsel;
          tx_data_q <= byte_mux;
        end
        S_WAIT: begin
          if (tx_byte_sent) guard_q <= CW'(GUARD_CYCLES - 1);
        end
        S_GUARD: begin
          if (!guard_done)              guard_q <= guard_q - 1'b1;
          else if (bsel_q != PIX_LO)    bsel_q  <= next_bsel(bsel_q);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pixel_streamer.sv
// Directed self-checking bench for uart_pixel_streamer with a transmitter model that
// returns byte_sent 20 cycles after each start.
module tb_uart_pixel_streamer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned GUARD = 4;
  localparam int unsigned TX_CYC = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       overflow;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_byte_sent = 1'b0;
  logic       busy;

  uart_pixel_streamer_if pix_bus ();

  uart_pixel_streamer #(
    .FIFO_DEPTH   (DEPTH),
    .GUARD_CYCLES (GUARD),
    .SYNC0        (8'hAA),
    .SYNC1        (8'h55)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pix          (pix_bus),
    .overflow     (overflow),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_byte_sent (tx_byte_sent),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // transmitter model state
  logic       tm_active = 1'b0;
  int         tm_cnt    = 0;
  logic [7:0] tm_byte   = 8'h00;
  int         n_starts  = 0;
  int         stable_err = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         start_cyc[$];
  int         sent_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc++;

  // Sampled mid-cycle; byte_sent driven mid-cycle so the DUT sees it at the next edge.
  always @(negedge clk) begin
    tx_byte_sent = 1'b0;
    if (reset) begin
      tm_active = 1'b0;
    end else begin
      if (tm_active) begin
        if (tx_data !== tm_byte) stable_err++;
        tm_cnt--;
        if (tm_cnt == 0) begin
          tx_byte_sent = 1'b1;
          tm_active    = 1'b0;
          sent_cyc.push_back(cyc);
        end
      end
      if (tx_start) begin
        tm_byte   = tx_data;
        tm_active = 1'b1;
        tm_cnt    = TX_CYC;
        rx_q.push_back(tx_data);
        start_cyc.push_back(cyc);
        n_starts++;
      end
    end
  end

  task automatic clear_log();
    rx_q.delete();
    exp_q.delete();
    start_cyc.delete();
    sent_cyc.delete();
    n_starts   = 0;
    stable_err = 0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    pix_bus.pix_valid = 1'b0;
    pix_bus.pix_sof   = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic push(input logic [15:0] d, input logic sof);
    pix_bus.pix_data  = d;
    pix_bus.pix_valid = 1'b1;
    pix_bus.pix_sof   = sof;
    @(posedge clk); #1;
    pix_bus.pix_valid = 1'b0;
    pix_bus.pix_sof   = 1'b0;
  endtask

  task automatic expect_pix(input logic [15:0] d, input logic sof);
    if (sof) begin
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'h55);
    end
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_starts(input string tag, input int target, input int budget);
    int n = 0;
    while (n_starts < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, n_starts, target);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
  endtask

  initial begin
    int acc;
    int target;
    pix_bus.pix_data  = 16'h0000;
    pix_bus.pix_valid = 1'b0;
    pix_bus.pix_sof   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_dut();

    // 1: reset state and single pixel latency
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'h00);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, pix_bus.pix_ready}, 32'd1);
    clear_log();
    push(16'h1234, 1'b0);
    check("lat_n1_start", {31'd0, tx_start}, 32'd0);
    @(posedge clk); #1;
    check("lat_n2_start", {31'd0, tx_start}, 32'd1);
    check("lat_n2_data", {24'd0, tx_data}, 32'h12);
    expect_pix(16'h1234, 1'b0);
    wait_idle("t1_idle", 500);
    compare_stream("t1");
    check("t1_starts", n_starts, 2);

    // 2/3: frame header, byte order, spacing, stability
    clear_log();
    push(16'hF81F, 1'b1);
    expect_pix(16'hF81F, 1'b1);
    wait_idle("t2_idle", 500);
    compare_stream("t2");
    check("t2_starts", n_starts, 4);
    for (int i = 1; i < 4 && i < start_cyc.size() && i <= sent_cyc.size(); i++)
      check($sformatf("t3_gap%0d", i), start_cyc[i] - sent_cyc[i-1], GUARD + 1);
    check("t3_stable", stable_err, 0);

    // 4: burst overruns the FIFO while the FSM is busy with a prior pixel
    reset_dut();
    clear_log();
    push(16'h0102, 1'b0);
    expect_pix(16'h0102, 1'b0);
    wait_starts("t4_warm", 1, 50);
    check("t4_ovf_pre", {31'd0, overflow}, 32'd0);
    acc = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      logic [15:0] d;
      d = {8'(8'h20 + i), 8'(8'h80 + i)};
      if (pix_bus.pix_ready) acc++;
      if (i < DEPTH) expect_pix(d, 1'b0);
      push(d, 1'b0);
    end
    check("t4_accepted", acc, DEPTH);
    check("t4_overflow", {31'd0, overflow}, 32'd1);
    wait_idle("t4_idle", 4000);
    compare_stream("t4");
    check("t4_stable", stable_err, 0);

    // 5: write colliding with a pop while full, then wrap the pointers
    reset_dut();
    clear_log();
    push(16'h7001, 1'b0);
    expect_pix(16'h7001, 1'b0);
    wait_starts("t5_warm", 1, 50);
    for (int i = 0; i < DEPTH; i++) begin
      logic [15:0] d;
      d = {8'(8'hC0 + i), 8'(8'h40 + i)};
      expect_pix(d, 1'b0);
      push(d, 1'b0);
    end
    check("t5_full_ready", {31'd0, pix_bus.pix_ready}, 32'd0);
    check("t5_full_ovf", {31'd0, overflow}, 32'd0);
    // warm pixel: 2 bytes x (TX_CYC + GUARD + 1) cycles, then the pop cycle in S_IDLE
    target = (start_cyc.size() > 0) ? start_cyc[0] + 2 * (TX_CYC + GUARD + 1) : cyc;
    while (cyc < target) begin
      @(posedge clk); #1;
    end
    check("t5_pop_ready", {31'd0, pix_bus.pix_ready}, 32'd0);
    push(16'hDEAD, 1'b0);
    check("t5_collide_ovf", {31'd0, overflow}, 32'd1);
    check("t5_post_pop_ready", {31'd0, pix_bus.pix_ready}, 32'd1);
    wait_idle("t5_drain", 4000);
    for (int i = 0; i < 6; i++) begin
      logic [15:0] d;
      d = {8'(8'h60 + i), 8'(8'hE0 + i)};
      expect_pix(d, 1'b0);
      push(d, 1'b0);
    end
    wait_idle("t5_idle", 2000);
    compare_stream("t5");

    // 6: reset during S_WAIT of a PIX_HI byte
    clear_log();
    push(16'h5A5A, 1'b0);
    wait_starts("t6_start", 1, 50);
    repeat (5) @(posedge clk);
    #1;
    reset_dut();
    check("t6_tx_start", {31'd0, tx_start}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_overflow", {31'd0, overflow}, 32'd0);
    check("t6_ready", {31'd0, pix_bus.pix_ready}, 32'd1);
    clear_log();
    push(16'hABCD, 1'b0);
    expect_pix(16'hABCD, 1'b0);
    wait_idle("t6_idle", 500);
    compare_stream("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
